// File: rtl/controller_pkg.sv
// controller_pkg: opcodes, T-state codes and the control-word layout for the bus computer.
// Optional feature macro EARLY_RETURN_EN selects between a fixed 7-state ring and early return.
// The control word is shared with the future microcode ROM, so its field order must stay fixed.
package controller_pkg;

  localparam int OP_W = 4;
  localparam int T_W  = 3;

  typedef logic [OP_W-1:0] op_t;
  typedef logic [T_W-1:0]  tstate_t;

  localparam op_t OP_LDA = 4'b0000;
  localparam op_t OP_ADD = 4'b0001;
  localparam op_t OP_SUB = 4'b0010;
  localparam op_t OP_OUT = 4'b1110;
  localparam op_t OP_HLT = 4'b1111;

  localparam tstate_t T1 = 3'd1;
  localparam tstate_t T2 = 3'd2;
  localparam tstate_t T3 = 3'd3;
  localparam tstate_t T4 = 3'd4;
  localparam tstate_t T5 = 3'd5;
  localparam tstate_t T6 = 3'd6;
  localparam tstate_t T7 = 3'd7;

  // Strobes in the order the ROM image will use, MSB first.
  typedef struct packed {
    logic pc_inc;
    logic pc_oe;
    logic mar_ld;
    logic ram_oe;
    logic ir_ld;
    logic ir_oe;
    logic acc_ld;
    logic acc_oe;
    logic breg_ld;
    logic sub;
    logic alu_oe;
    logic out_ld;
  } ctrl_word_t;

  // True in the final active T-state of an instruction; HLT never returns.
  function automatic logic is_last_state(tstate_t t, op_t op);
    case (op)
      OP_LDA:         return t == T5;
      OP_ADD, OP_SUB: return t == T7;
      OP_HLT:         return 1'b0;
      default:        return t == T4;
    endcase
  endfunction

endpackage

// File: rtl/controller_sequencer_if.sv
// controller_sequencer_if: opcode input and every control strobe of the sequencer.
// master = the sequencer (drives strobes), slave = the datapath (drives the opcode).
// T_STATE and HALT travel with the strobes for debug display.
interface controller_sequencer_if;
  import controller_pkg::*;

  logic [OP_W-1:0] IR_op;
  logic            PC_INC;
  logic            PC_OE;
  logic            MAR_LD;
  logic            RAM_OE;
  logic            IR_LD;
  logic            IR_OE;
  logic            ACC_LD;
  logic            ACC_OE;
  logic            BREG_LD;
  logic            SUB;
  logic            ALU_OE;
  logic            OUT_LD;
  logic            HALT;
  logic [T_W-1:0]  T_STATE;

  modport master (
    input  IR_op,
    output PC_INC, PC_OE, MAR_LD, RAM_OE, IR_LD, IR_OE, ACC_LD, ACC_OE,
           BREG_LD, SUB, ALU_OE, OUT_LD, HALT, T_STATE
  );

  modport slave (
    output IR_op,
    input  PC_INC, PC_OE, MAR_LD, RAM_OE, IR_LD, IR_OE, ACC_LD, ACC_OE,
           BREG_LD, SUB, ALU_OE, OUT_LD, HALT, T_STATE
  );

endinterface

// File: rtl/controller_sequencer_ring_counter.sv
// ring_counter: T-state counter T1..T7, async active-low clear to T1.
// One step per clock; hold freezes the count, load_t1 forces an early return to T1.
// hold has priority over load_t1.
module ring_counter
  import controller_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    hold,
  input  logic    load_t1,
  output tstate_t t_state
);

  tstate_t t_next;

  // State register: clear lands on T1 so fetch begins right away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) t_state <= T1;
    else        t_state <= t_next;
  end

  // Next state: hold, early return, wrap after T7, otherwise increment.
  always_comb begin
    t_next = t_state;
    if (hold)                          t_next = t_state;
    else if (load_t1 || t_state >= T7) t_next = T1;
    else                               t_next = t_state + tstate_t'(1);
  end

endmodule

// File: rtl/controller_sequencer.sv
// controller_sequencer: Moore decode of (T-state, opcode, halt) into bus strobes.
// Strobes are combinational from state; one T-state per clock; HLT freezes at T4.
// Macro EARLY_RETURN_EN: when defined, return to T1 after the last active T-state.
module controller_sequencer
  import controller_pkg::*;
(
  input  logic                   CLK,
  input  logic                   CLR_n,
  controller_sequencer_if.master bus
);

  tstate_t    t_state;
  logic       halt_q;
  logic       hlt_now;
  logic       load_t1;
  ctrl_word_t cw;

  // HLT is recognised in T4; holding the ring on that same edge parks T_STATE at 4.
  assign hlt_now = !halt_q && (t_state == T4) && (bus.IR_op == OP_HLT);

`ifdef EARLY_RETURN_EN
  assign load_t1 = !halt_q && is_last_state(t_state, bus.IR_op);
`else
  assign load_t1 = 1'b0;
`endif

  ring_counter u_ring (
    .clk     (CLK),
    .rst_n   (CLR_n),
    .hold    (halt_q | hlt_now),
    .load_t1 (load_t1),
    .t_state (t_state)
  );

  // Sticky halt flag; only the clear input releases it.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n)       halt_q <= 1'b0;
    else if (hlt_now) halt_q <= 1'b1;
  end

  // Control-word decode; at most one bus driver is ever enabled per state.
  always_comb begin
    cw = '0;
    if (!halt_q) begin
      case (t_state)
        T1: begin cw.pc_oe = 1'b1; cw.mar_ld = 1'b1; end
        T2: cw.pc_inc = 1'b1;
        T3: begin cw.ram_oe = 1'b1; cw.ir_ld = 1'b1; end
        T4: begin
          case (bus.IR_op)
            OP_LDA, OP_ADD, OP_SUB: begin cw.ir_oe = 1'b1; cw.mar_ld = 1'b1; end
            OP_OUT:                 begin cw.acc_oe = 1'b1; cw.out_ld = 1'b1; end
            default:                ;
          endcase
        end
        T5: begin
          case (bus.IR_op)
            OP_LDA: begin cw.ram_oe = 1'b1; cw.acc_ld = 1'b1; end
            OP_ADD, OP_SUB: begin
              cw.ram_oe  = 1'b1;
              cw.breg_ld = 1'b1;
              cw.sub     = (bus.IR_op == OP_SUB);
            end
            default: ;
          endcase
        end
        // T6 is the ALU capture cycle; SUB must already be steady here.
        T6: cw.sub = (bus.IR_op == OP_SUB);
        T7: begin
          if (bus.IR_op == OP_ADD || bus.IR_op == OP_SUB) begin
            cw.alu_oe = 1'b1;
            cw.acc_ld = 1'b1;
            cw.sub    = (bus.IR_op == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.PC_INC  = cw.pc_inc;
  assign bus.PC_OE   = cw.pc_oe;
  assign bus.MAR_LD  = cw.mar_ld;
  assign bus.RAM_OE  = cw.ram_oe;
  assign bus.IR_LD   = cw.ir_ld;
  assign bus.IR_OE   = cw.ir_oe;
  assign bus.ACC_LD  = cw.acc_ld;
  assign bus.ACC_OE  = cw.acc_oe;
  assign bus.BREG_LD = cw.breg_ld;
  assign bus.SUB     = cw.sub;
  assign bus.ALU_OE  = cw.alu_oe;
  assign bus.OUT_LD  = cw.out_ld;
  assign bus.HALT    = halt_q;
  assign bus.T_STATE = t_state;

endmodule

// File: tb/tb_controller_sequencer.sv
// tb_controller_sequencer: directed stepping of the sequencer with a tiny ALU/register model.
// Strobe words are packed {PC_INC,PC_OE,MAR_LD,RAM_OE,IR_LD,IR_OE,ACC_LD,ACC_OE,BREG_LD,SUB,ALU_OE,OUT_LD}.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_controller_sequencer;

  logic CLK;
  logic CLR_n;
  int   errors;
  int   checks;

  controller_sequencer_if ifc ();

  controller_sequencer dut (
    .CLK   (CLK),
    .CLR_n (CLR_n),
    .bus   (ifc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Minimal datapath: registered ALU, accumulator, B register, RAM operand fixed at 0x03.
  logic [7:0] acc, breg, alu_q, dbus;
  logic       preset;
  assign dbus = ifc.RAM_OE ? 8'h03 : ifc.ALU_OE ? alu_q : ifc.ACC_OE ? acc : 8'h00;
  always @(posedge CLK) begin
    alu_q <= ifc.SUB ? (acc - breg) : (acc + breg);
    if (preset)          acc <= 8'h10;
    else if (ifc.ACC_LD) acc <= dbus;
    if (ifc.BREG_LD)     breg <= dbus;
  end

  localparam logic [11:0] W_NONE = 12'h000;
  localparam logic [11:0] W_T1   = 12'h600;
  localparam logic [11:0] W_T2   = 12'h800;
  localparam logic [11:0] W_T3   = 12'h180;
  localparam logic [11:0] W_ADDR = 12'h240;
  localparam logic [11:0] W_LDA5 = 12'h120;
  localparam logic [11:0] W_ADD5 = 12'h108;
  localparam logic [11:0] W_ADD7 = 12'h022;
  localparam logic [11:0] W_SUB5 = 12'h10C;
  localparam logic [11:0] W_SUB6 = 12'h004;
  localparam logic [11:0] W_SUB7 = 12'h026;
  localparam logic [11:0] W_OUT4 = 12'h011;

  function automatic logic [11:0] obs_w();
    return {ifc.PC_INC, ifc.PC_OE, ifc.MAR_LD, ifc.RAM_OE, ifc.IR_LD, ifc.IR_OE,
            ifc.ACC_LD, ifc.ACC_OE, ifc.BREG_LD, ifc.SUB, ifc.ALU_OE, ifc.OUT_LD};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int t, input logic [11:0] w, input logic h);
    chk({tag, "_t"}, 32'(ifc.T_STATE), 32'(t));
    chk({tag, "_w"}, 32'(obs_w()), 32'(w));
    chk({tag, "_halt"}, 32'(ifc.HALT), 32'(h));
  endtask

  // Advance one clock, then check the new state.
  task automatic step(input string tag, input int t, input logic [11:0] w);
    @(negedge CLK);
    chk_state(tag, t, w, 1'b0);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    preset    = 1'b0;
    CLR_n     = 1'b0;
    ifc.IR_op = 4'b0001;

    // Reset state
    @(negedge CLK);
    chk_state("rst", 1, W_T1, 1'b0);
    CLR_n = 1'b1;
    #1 chk_state("rst_rel", 1, W_T1, 1'b0);

    // ADD, fixed ring
    step("add_t2", 2, W_T2);
    step("add_t3", 3, W_T3);
    step("add_t4", 4, W_ADDR);
    step("add_t5", 5, W_ADD5);
    step("add_t6", 6, W_NONE);
    step("add_t7", 7, W_ADD7);
    step("add_wrap", 1, W_T1);

    // SUB with ACC=0x10, RAM=0x03 -> ACC=0x0D
    ifc.IR_op = 4'b0010;
    preset = 1'b1;
    step("sub_t2", 2, W_T2);
    preset = 1'b0;
    step("sub_t3", 3, W_T3);
    step("sub_t4", 4, W_ADDR);
    step("sub_t5", 5, W_SUB5);
    step("sub_t6", 6, W_SUB6);
    step("sub_t7", 7, W_SUB7);
    step("sub_wrap", 1, W_T1);
    chk("sub_acc", 32'(acc), 32'h0D);

    // OUT, with HLT on IR_op during fetch (must be ignored)
    ifc.IR_op = 4'b1111;
    step("out_t2", 2, W_T2);
    step("out_t3", 3, W_T3);
    ifc.IR_op = 4'b1110;
    step("out_t4", 4, W_OUT4);
`ifdef EARLY_RETURN_EN
    step("out_ret", 1, W_T1);
`else
    step("out_t5", 5, W_NONE);
    step("out_t6", 6, W_NONE);
    step("out_t7", 7, W_NONE);
    step("out_wrap", 1, W_T1);
`endif

    // LDA
    ifc.IR_op = 4'b0000;
    step("lda_t2", 2, W_T2);
    step("lda_t3", 3, W_T3);
    step("lda_t4", 4, W_ADDR);
    step("lda_t5", 5, W_LDA5);
`ifdef EARLY_RETURN_EN
    step("lda_ret", 1, W_T1);
`else
    step("lda_t6", 6, W_NONE);
    step("lda_t7", 7, W_NONE);
    step("lda_wrap", 1, W_T1);
`endif

    // Undefined opcode behaves as NOP
    ifc.IR_op = 4'b0101;
    step("nop_t2", 2, W_T2);
    step("nop_t3", 3, W_T3);
    step("nop_t4", 4, W_NONE);
`ifdef EARLY_RETURN_EN
    step("nop_ret", 1, W_T1);
`else
    step("nop_t5", 5, W_NONE);
    step("nop_t6", 6, W_NONE);
    step("nop_t7", 7, W_NONE);
    step("nop_wrap", 1, W_T1);
`endif

    // Reset asserted mid-T5 of a SUB
    ifc.IR_op = 4'b0010;
    step("mr_t2", 2, W_T2);
    step("mr_t3", 3, W_T3);
    step("mr_t4", 4, W_ADDR);
    step("mr_t5", 5, W_SUB5);
    CLR_n = 1'b0;
    #1 chk_state("mr_rst", 1, W_T1, 1'b0);
    @(negedge CLK);
    CLR_n = 1'b1;
    #1 chk_state("mr_rel", 1, W_T1, 1'b0);
    step("mr_t2b", 2, W_T2);

    // Bus exclusivity under random opcodes (HLT excluded so the ring keeps moving)
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (ifc.T_STATE == 3'd3) ifc.IR_op = 4'($urandom_range(0, 14));
      #1 chk("bus_excl",
             32'($countones({ifc.PC_OE, ifc.RAM_OE, ifc.IR_OE, ifc.ACC_OE, ifc.ALU_OE}) > 1),
             32'd0);
    end

    // HLT: freeze at T4 with no strobes, then clear
    @(negedge CLK);
    CLR_n = 1'b0;
    ifc.IR_op = 4'b1111;
    @(negedge CLK);
    CLR_n = 1'b1;
    #1 chk_state("hlt_t1", 1, W_T1, 1'b0);
    step("hlt_t2", 2, W_T2);
    step("hlt_t3", 3, W_T3);
    step("hlt_t4", 4, W_NONE);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      ifc.IR_op = 4'($urandom_range(0, 15));
      #1 chk_state("hlt_hold", 4, W_NONE, 1'b1);
    end
    CLR_n = 1'b0;
    #1 chk_state("hlt_clr", 1, W_T1, 1'b0);
    @(negedge CLK);
    CLR_n = 1'b1;
    ifc.IR_op = 4'b0101;
    step("hlt_t2b", 2, W_T2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
